// File: rtl/serial_pkg.sv
// Shared definitions for the multi-lane bit-serial adder/subtractor.
// Ports: none (package only).
// Holds the controller state type and the default word/lane sizing.
package serial_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_lane.sv
// One bit-serial full-adder lane: carry flop, serial sum bit, result shift register.
// Latency: s is combinational from a/b/carry; sum/cout/ovf settle the cycle after the last bit.
// Backpressure: none; the lane advances only when en is high and holds otherwise.
// Ports: clk, rst (async active-low), init/init_sub (start of word),
//        sub (latched mode), run/en/last (from controller), a/b (operand bits),
//        s (serial result), sum (parallel result), cout, ovf.
module serial_fa_lane
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             init_sub,
  input  logic             sub,
  input  logic             run,
  input  logic             en,
  input  logic             last,
  input  logic             a,
  input  logic             b,
  output logic             s,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic carry;
  logic bx;
  logic s_raw;
  logic carry_nxt;

  // Subtraction is A + ~B + 1: invert B here, the +1 comes from the carry seed.
  assign bx        = b ^ sub;
  assign s_raw     = a ^ bx ^ carry;
  assign carry_nxt = (a & bx) | (a & carry) | (bx & carry);
  assign s         = run & s_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (init) begin
      carry <= init_sub;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (en) begin
      carry <= carry_nxt;
      // LSB arrives first, so shifting right leaves bit 0 at the bottom after WIDTH steps.
      sum   <= {s_raw, sum[WIDTH-1:1]};
      if (last) begin
        cout <= carry_nxt;
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf  <= carry ^ carry_nxt;
      end
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-lane bit-serial add/subtract with a shared IDLE/RUN/DONE controller.
// Latency: done rises the cycle after the WIDTH-th enabled bit (>= WIDTH+1 cycles after start).
// Backpressure: bit_en low stalls all lanes; start is ignored outside IDLE.
// Ports: clk, rst (async active-low), start, sub, bit_en, a/b (one bit per lane),
//        s (serial result bits), busy, done, sum_par (lane k at [k*WIDTH +: WIDTH]), cout, ovf.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   bit_en,
  input  logic [LANES-1:0]       a,
  input  logic [LANES-1:0]       b,
  output logic [LANES-1:0]       s,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*WIDTH-1:0] sum_par,
  output logic [LANES-1:0]       cout,
  output logic [LANES-1:0]       ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          sub_q;
  logic          init;
  logic          en;
  logic          last;

  assign init = (state == IDLE) && start;
  assign en   = (state == RUN) && bit_en;
  assign last = en && (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sub_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (init) begin
        cnt   <= '0;
        sub_q <= sub;
      end else if (en) begin
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    serial_fa_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .init    (init),
      .init_sub(sub),
      .sub     (sub_q),
      .run     (busy),
      .en      (en),
      .last    (last),
      .a       (a[k]),
      .b       (b[k]),
      .s       (s[k]),
      .sum     (sum_par[k*WIDTH +: WIDTH]),
      .cout    (cout[k]),
      .ovf     (ovf[k])
    );
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed word cases plus randomized words
// compared against integer-arithmetic expectations.
module tb_serial_addsub;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int LW = L * W;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sub;
  logic          bit_en;
  logic [L-1:0]  a;
  logic [L-1:0]  b;
  logic [L-1:0]  s;
  logic          busy;
  logic          done;
  logic [LW-1:0] sum_par;
  logic [L-1:0]  cout;
  logic [L-1:0]  ovf;

  int passed = 0;
  int total  = 0;

  serial_addsub #(.WIDTH(W), .LANES(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .bit_en (bit_en),
    .a      (a),
    .b      (b),
    .s      (s),
    .busy   (busy),
    .done   (done),
    .sum_par(sum_par),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Expected word result from plain integer arithmetic: {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sb);
    int sx, sy, r, ux, uy;
    logic c, o;
    logic [W-1:0] res;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    r  = sb ? (sx - sy) : (sx + sy);
    o  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    c  = sb ? (ux >= uy) : ((ux + uy) >= (2 ** W));
    res = W'(sb ? (ux - uy) : (ux + uy));
    return {o, c, res};
  endfunction

  // Runs one word. mode 0: bit_en always 1; 1: pattern 1,0,0 repeating; 2: random.
  // start_bit >= 0 re-pulses start in RUN (and holds it through DONE); rst_bit >= 0 aborts.
  task automatic run_word(input logic [LW-1:0] aw, input logic [LW-1:0] bw, input logic sb,
                          input int mode, input int start_bit, input int rst_bit,
                          output logic [LW-1:0] res, output logic [L-1:0] co,
                          output logic [L-1:0] ov, output int done_cyc);
    logic [LW-1:0] ew;
    logic [L-1:0]  ec, eo, es;
    logic [W+1:0]  m;
    logic          en;
    int i, k, cyc;
    for (int l = 0; l < L; l++) begin
      m = model(aw[l*W +: W], bw[l*W +: W], sb);
      ew[l*W +: W] = m[W-1:0];
      ec[l] = m[W];
      eo[l] = m[W+1];
    end
    res = '0; co = '0; ov = '0; done_cyc = -1;
    i = 0; k = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; sub = sb; bit_en = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    start = 1'b0;
    sub = 1'($urandom_range(0, 1));  // mode must be the one latched at start
    cyc = 1;
    while (i < W) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = (k % 3 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      for (int l = 0; l < L; l++) begin
        a[l] = aw[l*W + i];
        b[l] = bw[l*W + i];
        es[l] = ew[l*W + i];
      end
      bit_en = en;
      start = (i == start_bit);
      if (i == rst_bit) begin
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_sum", sum_par, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold_done", done, 0);
          chk("rst_hold_busy", busy, 0);
        end
        #1;
        rst = 1'b1; start = 1'b0; bit_en = 1'b0;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        return;
      end
      @(negedge clk);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_s", s, es);
      @(posedge clk); #1;
      cyc++; k++;
      if (en) i++;
      if (cyc > 20 * W) begin
        chk("timeout", 0, 1);
        return;
      end
    end
    start = (start_bit >= 0);  // held through DONE: must be ignored there too
    bit_en = 1'($urandom_range(0, 1));
    a = L'($urandom); b = L'($urandom);
    @(negedge clk);
    done_cyc = cyc;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_s", s, 0);
    chk("done_sum", sum_par, ew);
    chk("done_cout", cout, ec);
    chk("done_ovf", ovf, eo);
    res = sum_par; co = cout; ov = ovf;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_s", s, 0);
    chk("idle_sum_hold", sum_par, ew);
    chk("idle_cout_hold", cout, ec);
    chk("idle_ovf_hold", ovf, eo);
  endtask

  initial begin
    logic [LW-1:0] aw, bw, res;
    logic [L-1:0]  co, ov;
    int dc;
    rst = 1'b0; start = 1'b0; sub = 1'b0; bit_en = 1'b0; a = '0; b = '0;
    #23;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum_par, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_s", s, 0);
    #4 rst = 1'b1;

    // 0xAA + 0xAA
    aw = LW'($urandom); bw = LW'($urandom);
    aw[7:0] = 8'hAA; bw[7:0] = 8'hAA;
    run_word(aw, bw, 1'b0, 0, -1, -1, res, co, ov, dc);
    chk("aa_sum", res[7:0], 8'h54);
    chk("aa_cout", co[0], 1);
    chk("aa_ovf", ov[0], 1);
    chk("aa_done_cycle", dc, 9);

    // Subtract: 5-7 and 0x80-1
    aw = LW'($urandom); bw = LW'($urandom);
    aw[15:0] = 16'h8005; bw[15:0] = 16'h0107;
    run_word(aw, bw, 1'b1, 0, -1, -1, res, co, ov, dc);
    chk("sub0_sum", res[7:0], 8'hFE);
    chk("sub0_cout", co[0], 0);
    chk("sub0_ovf", ov[0], 0);
    chk("sub1_sum", res[15:8], 8'h7F);
    chk("sub1_cout", co[1], 1);
    chk("sub1_ovf", ov[1], 1);

    // Lane independence: 0x7F+1 overflows, 1+1 does not
    aw = LW'($urandom); bw = LW'($urandom);
    aw[15:0] = 16'h017F; bw[15:0] = 16'h0101;
    run_word(aw, bw, 1'b0, 0, -1, -1, res, co, ov, dc);
    chk("ind0_sum", res[7:0], 8'h80);
    chk("ind0_ovf", ov[0], 1);
    chk("ind1_sum", res[15:8], 8'h02);
    chk("ind1_ovf", ov[1], 0);

    // Stalls: bit_en 1,0,0 repeating -> 22 RUN cycles
    aw = LW'($urandom); bw = LW'($urandom);
    aw[7:0] = 8'h3C; bw[7:0] = 8'h0F;
    run_word(aw, bw, 1'b0, 1, -1, -1, res, co, ov, dc);
    chk("stall_sum", res[7:0], 8'h4B);
    chk("stall_done_cycle", dc, 23);

    // start re-pulsed at bit 3 and held in DONE: ignored
    aw = LW'($urandom); bw = LW'($urandom);
    run_word(aw, bw, 1'b0, 0, 3, -1, res, co, ov, dc);
    chk("restart_done_cycle", dc, 9);

    // Reset at bit 4 aborts the word
    aw = LW'($urandom); bw = LW'($urandom);
    run_word(aw, bw, 1'b1, 0, -1, 4, res, co, ov, dc);
    chk("abort_no_done", dc, -1);

    // Randomized words
    for (int n = 0; n < 40; n++) begin
      aw = LW'($urandom); bw = LW'($urandom);
      run_word(aw, bw, 1'($urandom_range(0, 1)), ((n % 2) == 0) ? 0 : 2, -1, -1,
               res, co, ov, dc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand word length in bits (>=2).
REQ-002 Parameter LANES, default 4, SHALL set the number of independent serial add/sub channels (>=1).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port start  input  1  SHALL request a new word operation (sampled in IDLE only).
REQ-006 Port sub  input  1  SHALL select mode, 0 = A+B, 1 = A-B; sampled with start.
REQ-007 Port bit_en  input  1  SHALL advance one bit position per cycle when high in RUN.
REQ-008 Port a  input  LANES  SHALL carry the current operand-A bit per lane, LSB first.
REQ-009 Port b  input  LANES  SHALL carry the current operand-B bit per lane, LSB first.
REQ-010 Port s  output  LANES  SHALL give the current serial result bit per lane.
REQ-011 Port busy  output  1  SHALL be high in RUN.
REQ-012 Port done  output  1  SHALL pulse high for exactly one cycle when a word completes.
REQ-013 Port sum_par  output  LANES*WIDTH  SHALL hold the parallel result, lane k at bits [k*WIDTH +: WIDTH].
REQ-014 Port cout  output  LANES  SHALL hold the final carry-out per lane (1 = no borrow in sub mode).
REQ-015 Port ovf  output  LANES  SHALL hold the two's-complement signed-overflow flag per lane.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE with start=1 SHALL go to RUN next cycle, latch sub, clear bit counter, set every lane carry to sub, and clear sum_par.
REQ-018 In RUN with bit_en=1, each lane SHALL compute s = a ^ (b ^ sub) ^ carry, update carry = majority(a, b^sub, carry), shift s into sum_par lane MSB (right-shift), and increment the counter.
REQ-019 In RUN with bit_en=0, counter, carries and sum_par SHALL hold (stall); s still reflects current inputs.
REQ-020 s SHALL be 0 outside RUN.
REQ-021 On the enabled cycle with counter = WIDTH-1, FSM SHALL go to DONE; counter wraps to 0.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; sum_par, cout, ovf SHALL be valid from DONE and held until the next start is accepted.
REQ-023 cout SHALL equal the carry out of bit WIDTH-1; ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-024 start asserted in RUN or DONE SHALL be ignored (no restart, no queueing).
REQ-025 Latency: done SHALL rise the cycle after the WIDTH-th enabled bit cycle; minimum WIDTH+1 cycles after start acceptance.
REQ-026 Lanes SHALL be fully independent except for shared start, sub, bit_en and FSM.

Reset
REQ-027 rst low SHALL immediately force state IDLE, counter 0, carries 0, sum_par 0, cout 0, ovf 0, busy 0, done 0, s 0.
REQ-028 Reset asserted mid-RUN SHALL abort the word with no done pulse; outputs cleared per REQ-027.

Structure
REQ-029 Shared package serial_pkg SHALL hold the FSM state type (IDLE/RUN/DONE) and default WIDTH/LANES constants.
REQ-030 One sub-module serial_fa_lane (carry flop, sum bit, MSB carry capture) SHALL be instantiated LANES times; FSM and counter SHALL live in the top.

Verification
REQ-031 WIDTH=8, lane0 A=0xAA B=0xAA add, bit_en always 1 -> sum_par lane0 0x54, cout=1, ovf=1, done at cycle 9 after start.
REQ-032 Sub, lane0 A=0x05 B=0x07 -> 0xFE, cout=0, ovf=0; lane1 A=0x80 B=0x01 -> 0x7F, cout=1, ovf=1.
REQ-033 Add, lane0 A=0x7F B=0x01, lane1 A=0x01 B=0x01 -> lane0 0x80 ovf=1, lane1 0x02 ovf=0 (lane independence).
REQ-034 bit_en toggled 1,0,0,1,... with A=0x3C B=0x0F add -> result 0x4B unchanged by stalls, done after 8 enabled cycles only.
REQ-035 start pulsed at bit 3 of a RUN word -> ignored, result correct; rst low at bit 4 -> IDLE, no done, all outputs 0.
